// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor evaluation per clock, LSB first,
// behind valid/ready handshakes. Define SERIAL_SUB_OVF_EN to add the Ovf output.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_b;
  logic w_last;

  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_d    = w_ai ^ w_bi ^ r_c;
  assign w_b    = (~w_ai & w_bi) | (w_bi & r_c) | (r_c & ~w_ai);
  assign w_last = (r_cnt == CW'(WIDTH));

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during RUN, so keep copies for the overflow term.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
  logic w_ovf;

  assign w_ovf = (r_a_msb != r_b_msb) & (r_res[WIDTH-1] != r_a_msb);
  assign Ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_valid) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (r_state == S_RUN && w_last) begin
        r_ovf <= w_ovf;
      end
    end
  end
`endif

  // RUN spends WIDTH cycles evaluating bits plus one cycle publishing the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_c      <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= Bin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_diff   <= r_res;
            r_borrow <= r_c;
            r_state  <= S_DONE;
          end else begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
            r_c   <= w_b;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (done_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign Diff        = r_diff;
  assign Borrow      = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH=8.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic [7:0] Diff;
  logic       Borrow;
  logic       done_valid;
  logic       done_ready;
  logic       busy;
`ifdef SERIAL_SUB_OVF_EN
  logic       Ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .Bin         (Bin),
    .Diff        (Diff),
    .Borrow      (Borrow),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf         (Ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Handshake the operands in, then wait (bounded) for done_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat);
    A = a; B = b; Bin = bin; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = Diff;
    bo = Borrow;
`ifdef SERIAL_SUB_OVF_EN
    ov = Ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic finish_op();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  initial begin
    vec_t       vecs[10];
    exp_t       q[$];
    exp_t       e;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         lat;
    logic [7:0] ra, rb;
    logic       rbin;
    int         n_acc, n_done, last_done;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    #12;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_borrow", Borrow, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_diff", i), d, vecs[i].diff);
      chk($sformatf("vec%0d_borrow", i), bo, vecs[i].borrow);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
`endif
      finish_op();
    end

    // Back-pressure in DONE with start_valid pulses that must be ignored.
    run_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_done_valid", done_valid, 1);
      chk("bp_diff", Diff, 8'h02);
      chk("bp_borrow", Borrow, 0);
      chk("bp_start_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    finish_op();
    chk("bp_release_start_ready", start_ready, 1);
    chk("bp_release_done_valid", done_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Asynchronous reset at RUN bit 4; Diff currently holds 8'h02.
    A = 8'hAA; B = 8'h55; Bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done_valid", done_valid, 0);
    chk("arst_start_ready", start_ready, 1);
    chk("arst_diff", Diff, 0);
    chk("arst_borrow", Borrow, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8'h01, 1'b0, d, bo, ov, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_diff", d, 8'h0F);
    chk("post_rst_borrow", bo, 0);
    finish_op();

    // 200 back-to-back random ops with start_valid and done_ready held high.
    n_acc = 0; n_done = 0; last_done = 0;
    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    A = ra; B = rb; Bin = rbin;
    start_valid = 1'b1; done_ready = 1'b1;
    for (int it = 0; it < 5000 && n_done < 200; it++) begin
      @(negedge clk);
      if (start_ready && done_valid) chk("overlap_ready_valid", 1, 0);
      if (done_valid && done_ready) begin
        if (q.size() == 0) begin
          chk("sweep_unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sweep_result", {Borrow, Diff}, {e.borrow, e.diff});
        end
        last_done = cyc_cnt;
        n_done++;
      end
      if (start_valid && start_ready) begin
        e.diff   = ra - rb - 8'(rbin);
        e.borrow = ({1'b0, ra} < ({1'b0, rb} + 9'(rbin)));
        q.push_back(e);
        if (n_acc > 0) chk("b2b_accept_gap", cyc_cnt - last_done, 1);
        n_acc++;
        @(posedge clk); #1;
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        A = ra; B = rb; Bin = rbin;
        if (n_acc == 200) start_valid = 1'b0;
      end
    end
    chk("sweep_done_count", n_done, 200);
    start_valid = 1'b0; done_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
